mem_rmw_unit: RTL

// - Load/store access unit between the multicycle core datapath and the word-wide Memoria block.
// - Accepts one word, halfword or byte request at a time.
// - Sub-word stores run as read-modify-write: read the word, merge the lanes, write the word back.
// - Sub-word loads are extracted from the word and sign- or zero-extended.
// - Replaces the combinational byte/halfword muxing around the memory port with one sequenced, checked path.

---
 rtl/mem_rmw_unit_if.sv | 34 +++
 rtl/mem_rmw_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_rmw_unit_if.sv
// Request/response and Memoria bus bundle for mem_rmw_unit.
// slave = the access unit, master = core plus memory side.
interface mem_rmw_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_signed, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, mem_addr, mem_wr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size,
    output req_signed, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_rmw_unit.sv
// Load/store access unit for the word-wide Memoria block.
// Sub-word stores run as read-modify-write; loads are lane-extracted.
module mem_rmw_unit #(
  parameter int MEM_RD_LAT = 1
) (
  input logic           Clk,
  input logic           reset,
  mem_rmw_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam int CW = $clog2(MEM_RD_LAT + 1) + 1;
  localparam logic [CW-1:0] RD_LAST = CW'(MEM_RD_LAT);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic          sgn_q, sgn_d;
  logic [1:0]    lo_q, lo_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;

  logic          idle;
  logic          accept;
  logic          bad;
  logic          is_byte;
  logic          is_half;
  logic [4:0]    bsh;
  logic [4:0]    hsh;
  logic [31:0]   bsel;
  logic [15:0]   hsel;
  logic [31:0]   ld_word;
  logic [31:0]   st_word;

  assign idle   = (state_q == S_IDLE);
  assign accept = bus.req_valid & idle & ~reset;

  // misaligned or illegal-size requests never touch memory
  assign bad = (bus.req_size == 2'b11)
             | ((bus.req_size == 2'b01) & bus.req_addr[0])
             | ((bus.req_size == 2'b00) & (bus.req_addr[1:0] != 2'b00));

  assign is_byte = (size_q == 2'b10);
  assign is_half = (size_q == 2'b01);
  assign bsh     = {lo_q, 3'b000};
  assign hsh     = {lo_q[1], 4'b0000};
  assign bsel    = bus.mem_rdata >> bsh;
  assign hsel    = lo_q[1] ? bus.mem_rdata[31:16]
                           : bus.mem_rdata[15:0];

  always_comb begin
    ld_word = bus.mem_rdata;
    unique case (1'b1)
      is_byte: ld_word = {{24{sgn_q & bsel[7]}}, bsel[7:0]};
      is_half: ld_word = {{16{sgn_q & hsel[15]}}, hsel};
      default: ld_word = bus.mem_rdata;
    endcase
  end

  always_comb begin
    st_word = bus.mem_rdata;
    unique case (1'b1)
      is_byte: st_word = (bus.mem_rdata & ~(32'h0000_00ff << bsh))
                       | ({24'd0, wdata_q[7:0]} << bsh);
      is_half: st_word = (bus.mem_rdata & ~(32'h0000_ffff << hsh))
                       | ({16'd0, wdata_q} << hsh);
      default: st_word = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    lo_d         = lo_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr_d    = bus.req_write;
          size_d  = bus.req_size;
          sgn_d   = bus.req_signed;
          lo_d    = bus.req_addr[1:0];
          wdata_d = bus.req_wdata[15:0];
          cnt_d   = '0;
          if (bad) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            mem_addr_d = {bus.req_addr[31:2], 2'b00};
            if (bus.req_write && bus.req_size == 2'b00) begin
              mem_wdata_d = bus.req_wdata;
              state_d     = S_WR;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        if (cnt_q == RD_LAST) begin
          if (wr_q) begin
            mem_wdata_d = st_word;
            state_d     = S_WR;
          end else begin
            resp_rdata_d = ld_word;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR: begin
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      lo_q         <= 2'b00;
      wdata_q      <= 16'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      lo_q         <= lo_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = idle & ~reset;
  assign bus.mem_wr     = (state_q == S_WR) & ~reset;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule
